// File: rtl/branch_pkg.sv
// Shared opcode/funct3 constants and branch-type decode for the branch unit.
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BT_NONE,
    BT_COND,
    BT_JAL,
    BT_JALR
  } br_type_e;

  function automatic br_type_e decode_type(input logic [6:0] opc);
    br_type_e bt;
    case (opc)
      OPC_BRANCH: bt = BT_COND;
      OPC_JAL:    bt = BT_JAL;
      OPC_JALR:   bt = BT_JALR;
      default:    bt = BT_NONE;
    endcase
    return bt;
  endfunction

endpackage

// File: rtl/branch_if.sv
// Bundle of all branch_unit signals; the clock comes in from the environment.
interface branch_if #(parameter int XLEN = 32) (input logic clk);
  logic            rst;
  logic [31:0]     instr;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] op3;
  logic            enable;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] ret_addr;
endinterface

// File: rtl/branch_cmp.sv
// Conditional-branch comparator, purely combinational; reserved funct3 codes
// (010, 011) report not-taken.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      funct3,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (op1 == op2);
      F3_BNE:  taken = (op1 != op2);
      F3_BLT:  taken = ($signed(op1) <  $signed(op2));
      F3_BGE:  taken = ($signed(op1) >= $signed(op2));
      F3_BLTU: taken = (op1 <  op2);
      F3_BGEU: taken = (op1 >= op2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// PC / link register update for branches, JAL and JALR; one-cycle latency,
// no backpressure -- enable=0 simply holds both registers.
module branch_unit
  import branch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] op3,
  input  logic            enable,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] ret_addr
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ret_q, ret_d;
  logic [XLEN-1:0] seq_pc, rel_tgt, jalr_tgt;
  logic            taken;
  br_type_e        br_type;

  // Only opcode and funct3 matter here; the rest of the word is already decoded upstream.
  logic unused_instr;
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  assign br_type  = decode_type(instr[6:0]);
  assign seq_pc   = pc_q + XLEN'(4);
  assign rel_tgt  = (pc_q + op3) & ALIGN_MASK;
  assign jalr_tgt = (op1 + op3) & ALIGN_MASK;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .op1    (op1),
    .op2    (op2),
    .funct3 (instr[14:12]),
    .taken  (taken)
  );

  always_comb begin
    pc_d  = pc_q;
    ret_d = ret_q;
    if (enable) begin
      case (br_type)
        BT_COND: pc_d = taken ? rel_tgt : seq_pc;
        BT_JAL: begin
          pc_d  = rel_tgt;
          ret_d = seq_pc;
        end
        BT_JALR: begin
          pc_d  = jalr_tgt;
          ret_d = seq_pc;
        end
        default: pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      ret_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ret_q <= ret_d;
    end
  end

  assign pc_out   = pc_q;
  assign ret_addr = ret_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus randomized
// instruction streams against a spec-level reference model.
module tb_branch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  branch_if #(.XLEN(32)) bif (.clk(clk));

  branch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk      (bif.clk),
    .rst      (bif.rst),
    .instr    (bif.instr),
    .op1      (bif.op1),
    .op2      (bif.op2),
    .op3      (bif.op3),
    .enable   (bif.enable),
    .pc_out   (bif.pc_out),
    .ret_addr (bif.ret_addr)
  );

  int vec  = 0;
  int miss = 0;

  logic [31:0] pc_m, ret_m;

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic en);
    bif.instr  = ins;
    bif.op1    = a;
    bif.op2    = b;
    bif.op3    = c;
    bif.enable = en;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    bif.rst = 1'b0;
    #2;
    bif.rst = 1'b1;
    pc_m  = 32'h0;
    ret_m = 32'h0;
  endtask

  // Reference model: next PC/link from the ISA rules, using 64-bit sums truncated to 32 bits.
  task automatic model_step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic en);
    longint unsigned link, rel, ind;
    bit tk;
    longint sa, sb;
    if (!en) return;
    link = (longint'(pc_m) + 4) % 64'h1_0000_0000;
    rel  = ((longint'(pc_m) + longint'(c)) % 64'h1_0000_0000) / 2 * 2;
    ind  = ((longint'(a) + longint'(c)) % 64'h1_0000_0000) / 2 * 2;
    sa   = a[31] ? longint'(a) - 64'h1_0000_0000 : longint'(a);
    sb   = b[31] ? longint'(b) - 64'h1_0000_0000 : longint'(b);
    case (ins[6:0])
      7'b1100011: begin
        case (ins[14:12])
          3'd0:    tk = (a == b);
          3'd1:    tk = (a != b);
          3'd4:    tk = (sa < sb);
          3'd5:    tk = (sa >= sb);
          3'd6:    tk = (longint'(a) < longint'(b));
          3'd7:    tk = (longint'(a) >= longint'(b));
          default: tk = 1'b0;
        endcase
        pc_m = tk ? rel[31:0] : link[31:0];
      end
      7'b1101111: begin
        ret_m = link[31:0];
        pc_m  = rel[31:0];
      end
      7'b1100111: begin
        ret_m = link[31:0];
        pc_m  = ind[31:0];
      end
      default: pc_m = link[31:0];
    endcase
  endtask

  task automatic test_reset();
    bif.rst = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom, 1'b1);
    #20;
    vec++;
    if (bif.pc_out !== 32'h0) begin
      miss++; $display("FAIL reset_pc: got %h want %h", bif.pc_out, 32'h0);
    end
    vec++;
    if (bif.ret_addr !== 32'h0) begin
      miss++; $display("FAIL reset_ret: got %h want %h", bif.ret_addr, 32'h0);
    end
    bif.rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, 1'b0);
      cyc();
      vec++;
      if (bif.pc_out !== 32'h0 || bif.ret_addr !== 32'h0) begin
        miss++; $display("FAIL hold_after_reset[%0d]: got pc=%h ret=%h want pc=0 ret=0",
                         i, bif.pc_out, bif.ret_addr);
      end
    end
  endtask

  task automatic test_seq_beq();
    drive(32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h4) begin
      miss++; $display("FAIL seq_nop: got %h want %h", bif.pc_out, 32'h4);
    end
    drive(32'h0000_0063, 32'h5, 32'h5, 32'h20, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h24) begin
      miss++; $display("FAIL beq_taken: got %h want %h", bif.pc_out, 32'h24);
    end
    drive(32'h0000_0063, 32'h5, 32'h6, 32'h20, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h28) begin
      miss++; $display("FAIL beq_not_taken: got %h want %h", bif.pc_out, 32'h28);
    end
    vec++;
    if (bif.ret_addr !== 32'h0) begin
      miss++; $display("FAIL beq_ret_hold: got %h want %h", bif.ret_addr, 32'h0);
    end
  endtask

  task automatic test_signed();
    drive(32'h0000_4063, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h38) begin
      miss++; $display("FAIL blt_signed: got %h want %h", bif.pc_out, 32'h38);
    end
    drive(32'h0000_6063, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h3C) begin
      miss++; $display("FAIL bltu_unsigned: got %h want %h", bif.pc_out, 32'h3C);
    end
    // funct3 010 is reserved: always falls through even when operands are equal
    drive(32'h0000_2063, 32'h7, 32'h7, 32'h100, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h40) begin
      miss++; $display("FAIL f3_010_not_taken: got %h want %h", bif.pc_out, 32'h40);
    end
  endtask

  task automatic test_jal();
    drive(32'h0000_006F, 32'h0, 32'h0, 32'h100, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h140 || bif.ret_addr !== 32'h44) begin
      miss++; $display("FAIL jal_fwd: got pc=%h ret=%h want pc=%h ret=%h",
                       bif.pc_out, bif.ret_addr, 32'h140, 32'h44);
    end
    do_reset();
    drive(32'h0000_006F, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'hFFFF_FFF0 || bif.ret_addr !== 32'h4) begin
      miss++; $display("FAIL jal_wrap: got pc=%h ret=%h want pc=%h ret=%h",
                       bif.pc_out, bif.ret_addr, 32'hFFFF_FFF0, 32'h4);
    end
    drive(32'h0000_006F, 32'h0, 32'h0, 32'h11, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h0000_0000 || bif.ret_addr !== 32'hFFFF_FFF4) begin
      miss++; $display("FAIL jal_bit0_clear: got pc=%h ret=%h want pc=%h ret=%h",
                       bif.pc_out, bif.ret_addr, 32'h0, 32'hFFFF_FFF4);
    end
  endtask

  task automatic test_jalr();
    do_reset();
    drive(32'h0000_006F, 32'h0, 32'h0, 32'h80, 1'b1);
    cyc();
    drive(32'h0000_0067, 32'h1001, 32'h0, 32'h4, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h1004 || bif.ret_addr !== 32'h84) begin
      miss++; $display("FAIL jalr: got pc=%h ret=%h want pc=%h ret=%h",
                       bif.pc_out, bif.ret_addr, 32'h1004, 32'h84);
    end
    drive(32'h0000_0067, 32'h2000, 32'h0, 32'h2, 1'b1);
    cyc();
    vec++;
    if (bif.pc_out !== 32'h2002 || bif.ret_addr !== 32'h1008) begin
      miss++; $display("FAIL jalr_bit1_pass: got pc=%h ret=%h want pc=%h ret=%h",
                       bif.pc_out, bif.ret_addr, 32'h2002, 32'h1008);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(32'h0000_006F, 32'h0, 32'h0, 32'h40, 1'b1);
    cyc();
    #3;
    bif.rst = 1'b0;
    #1;
    vec++;
    if (bif.pc_out !== 32'h0 || bif.ret_addr !== 32'h0) begin
      miss++; $display("FAIL async_reset: got pc=%h ret=%h want pc=0 ret=0",
                       bif.pc_out, bif.ret_addr);
    end
    cyc();
    vec++;
    if (bif.pc_out !== 32'h0 || bif.ret_addr !== 32'h0) begin
      miss++; $display("FAIL reset_over_edge: got pc=%h ret=%h want pc=0 ret=0",
                       bif.pc_out, bif.ret_addr);
    end
    #2;
    bif.rst = 1'b1;
    cyc();
    vec++;
    if (bif.pc_out !== 32'h40 || bif.ret_addr !== 32'h4) begin
      miss++; $display("FAIL first_after_reset: got pc=%h ret=%h want pc=%h ret=%h",
                       bif.pc_out, bif.ret_addr, 32'h40, 32'h4);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, a, b, c;
    logic        en;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 3))
        0: ins[6:0] = 7'b1100011;
        1: ins[6:0] = 7'b1101111;
        2: ins[6:0] = 7'b1100111;
        default: if (ins[6:0] == 7'b1100011 || ins[6:0] == 7'b1101111 ||
                     ins[6:0] == 7'b1100111) ins[6:0] = 7'b0110011;
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {~a[31], a[30:0]};
        default: b = $urandom;
      endcase
      c  = $urandom;
      en = ($urandom_range(0, 3) != 0);
      drive(ins, a, b, c, en);
      model_step(ins, a, b, c, en);
      cyc();
      vec++;
      if (bif.pc_out !== pc_m || bif.ret_addr !== ret_m) begin
        miss++; $display("FAIL random[%0d] instr=%h: got pc=%h ret=%h want pc=%h ret=%h",
                         i, ins, bif.pc_out, bif.ret_addr, pc_m, ret_m);
      end
    end
  endtask

  initial begin
    bif.rst = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_seq_beq();
    test_signed();
    test_jal();
    test_jalr();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port instr, input, 32, RV32I instruction; opcode is [6:0], funct3 is [14:12].
REQ-006 SHALL have port op1, input, XLEN, rs1 value.
REQ-007 SHALL have port op2, input, XLEN, rs2 value.
REQ-008 SHALL have port op3, input, XLEN, sign-extended immediate offset, already decoded by the caller.
REQ-009 SHALL have port enable, input, 1, evaluates instr in the current cycle when high.
REQ-010 SHALL have port pc_out, output, XLEN, registered program counter.
REQ-011 SHALL have port ret_addr, output, XLEN, registered link (return) address.

Function
REQ-012 SHALL hold pc_out and ret_addr unchanged on any rising clk edge with enable=0.
REQ-013 SHALL treat opcode 1100011 as a conditional branch, with funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
REQ-014 SHALL treat funct3 010 or 011 under the branch opcode as not-taken.
REQ-015 SHALL, with enable=1 and a taken branch, load pc_out with pc_out+op3; when not taken, it SHALL load pc_out+4.
REQ-016 SHALL, with enable=1 and JAL (opcode 1101111), load pc_out with pc_out+op3 and ret_addr with the old pc_out+4.
REQ-017 SHALL, with enable=1 and JALR (opcode 1100111), load pc_out with (op1+op3) with bit 0 cleared, and ret_addr with the old pc_out+4.
REQ-018 SHALL, with enable=1 and any other opcode, load pc_out with pc_out+4.
REQ-019 SHALL leave ret_addr unchanged for every instruction except JAL and JALR.
REQ-020 SHALL compute all additions modulo 2^XLEN, wrapping silently with no overflow flag.
REQ-021 SHALL clear target bit 0 for branches and JAL.
REQ-022 SHALL raise no misalignment exception; bit 1 of the target passes through.
REQ-023 SHALL have a one-cycle latency: the result of the instr presented in cycle N is visible on pc_out/ret_addr after edge N.
REQ-024 SHALL be a purely combinational decision path from registered pc_out plus inputs to the next-state logic, with no internal pipeline.

Reset
REQ-025 SHALL, while rst=0, asynchronously force pc_out=RESET_PC and ret_addr=0, regardless of clk or enable.
REQ-026 SHALL, on rst deassertion, take the first update at the next rising clk edge with enable=1.
REQ-027 SHALL, if reset is asserted mid-sequence, discard any pending decision.

Structure
REQ-028 SHALL place the opcode constants (BRANCH, JAL, JALR) and the funct3 constants in a shared package branch_pkg.
REQ-029 SHALL define a branch-type enum in branch_pkg.
REQ-030 SHALL implement the condition evaluation in one combinational sub-module, branch_cmp, with inputs op1, op2 and funct3, and output taken.
REQ-031 SHALL be driven by the bench through interface branch_if (clk, rst, plus all DUT signals).

Verification
REQ-032 Reset: rst=0 for 20 ns -> pc_out=0, ret_addr=0; after rst=1 with enable=0 for 5 cycles -> values unchanged.
REQ-033 Sequential/BEQ: from pc=0, instr=32'h00000013 with enable=1 -> pc=4; then instr=32'h00000063, op1=op2=5, op3=32'h20 -> pc=32'h24; same instruction with op2=6 -> pc=32'h28.
REQ-034 Signed vs unsigned: op1=32'hFFFFFFFF, op2=1, op3=32'h10: BLT (funct3 100) -> taken, pc+=16; BLTU (funct3 110) -> not taken, pc+=4.
REQ-035 JAL: with pc=32'h40, instr=32'h0000006F, op3=32'h100 -> pc=32'h140, ret_addr=32'h44; negative op3=32'hFFFFFFF0 from pc=0 -> pc=32'hFFFFFFF0 (wrap).
REQ-036 JALR: with pc=32'h80, instr=32'h00000067, op1=32'h1001, op3=4 -> pc=32'h1004, ret_addr=32'h84.
REQ-037 Reset mid-operation: assert rst=0 between clock edges during a JAL sequence -> pc_out=0 and ret_addr=0 immediately, without waiting for clk.
